// File: rtl/sevseg_ctrl.sv
// sevseg_ctrl: MMIO seven-segment controller. Holds VALUE/CTRL/RAWSEG
// registers in a 16-byte window, decodes hex digits and scans four digits.
module sevseg_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_bus,
  input  logic [31:0] data_bus_in,
  input  logic [3:0]  data_mask_bus,
  input  logic        wr_bus,
  input  logic        rd_bus,
  output logic [31:0] data_bus_out,
  output logic [6:0]  seg,
  output logic [3:0]  sel
);

  localparam int             DW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]     SEL_OFF  = SEL_ACTIVE_LOW ? 4'hF : 4'h0;

  logic        hit;
  logic [1:0]  rsel;
  assign hit  = (addr_bus[31:4] == 28'h7000002);
  assign rsel = addr_bus[3:2];

  // ctrl_q packs only the implemented bits: {BLANK[3:0], RAW, EN}
  logic [15:0]     value_q, value_d;
  logic [5:0]      ctrl_q, ctrl_d;
  logic [3:0][6:0] raw_q, raw_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      sel_q, sel_d;

  logic [31:0] rd_mux;
  logic [3:0]  nib;
  logic [6:0]  hex, pat, seg_act;
  logic [3:0]  blank, sel_act;
  logic        lit;

  // address bits below word granularity and the RAWSEG bit 7 lanes are never stored
  logic unused_bits;
  assign unused_bits = ^{addr_bus[1:0], data_bus_in[31], data_bus_in[23]};

  // register file writes: byte lanes gated by the mask, held strobes are idempotent
  always_comb begin
    value_d = value_q;
    ctrl_d  = ctrl_q;
    raw_d   = raw_q;
    if (wr_bus && hit) begin
      case (rsel)
        2'd0: for (int b = 0; b < 2; b++)
                if (data_mask_bus[b]) value_d[8*b +: 8] = data_bus_in[8*b +: 8];
        2'd1: if (data_mask_bus[0]) ctrl_d = {data_bus_in[7:4], data_bus_in[1:0]};
        2'd2: for (int b = 0; b < 4; b++)
                if (data_mask_bus[b]) raw_d[b] = data_bus_in[8*b +: 7];
        default: ;
      endcase
    end
  end

  // readback mux uses pre-write state, so a same-cycle write returns the old value
  always_comb begin
    case (rsel)
      2'd0:    rd_mux = {16'h0, value_q};
      2'd1:    rd_mux = {24'h0, ctrl_q[5:2], 2'b00, ctrl_q[1:0]};
      2'd2:    rd_mux = {1'b0, raw_q[3], 1'b0, raw_q[2], 1'b0, raw_q[1], 1'b0, raw_q[0]};
      default: rd_mux = 32'h0;
    endcase
    rdata_d = (rd_bus && hit) ? rd_mux : 32'h0;
  end

  // scan divider: idx advances once per SCAN_DIV cycles, independent of EN
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // digit pattern selection, blanking and output polarity
  always_comb begin
    nib = value_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'h0: hex = 7'h3F;  4'h1: hex = 7'h06;  4'h2: hex = 7'h5B;  4'h3: hex = 7'h4F;
      4'h4: hex = 7'h66;  4'h5: hex = 7'h6D;  4'h6: hex = 7'h7D;  4'h7: hex = 7'h07;
      4'h8: hex = 7'h7F;  4'h9: hex = 7'h6F;  4'hA: hex = 7'h77;  4'hB: hex = 7'h7C;
      4'hC: hex = 7'h39;  4'hD: hex = 7'h5E;  4'hE: hex = 7'h79;  default: hex = 7'h71;
    endcase
    pat     = ctrl_q[1] ? raw_q[idx_q] : hex;
    blank   = ctrl_q[5:2];
    lit     = ctrl_q[0] && !blank[idx_q];
    seg_act = lit ? pat : 7'h00;
    sel_act = lit ? (4'b0001 << idx_q) : 4'h0;
    seg_d   = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    sel_d   = SEL_ACTIVE_LOW ? ~sel_act : sel_act;
  end

  // state registers with synchronous reset; reset wins over a concurrent write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
      ctrl_q  <= 6'b000001;
      raw_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
    end else begin
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      raw_q   <= raw_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign data_bus_out = rdata_q;
  assign seg          = seg_q;
  assign sel          = sel_q;

endmodule
